// File: rtl/spi_slave_reg_ctrl.sv
// rtl/spi_slave_reg_ctrl.sv - SPI slave frame sequencer driving an 8-bit register bus
module spi_slave_reg_ctrl #(
    parameter int unsigned ADDR_W      = 7,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              spi_rdy_i,
    output logic              spi_rdy_ack_o,
    input  logic [7:0]        spi_data_i,
    output logic [7:0]        spi_data_o,
    input  logic              spi_first_byte_i,
    input  logic              spi_last_byte_i,
    output logic              spi_last_byte_ack_o,
    output logic [ADDR_W-1:0] reg_addr_o,
    output logic [7:0]        reg_wdata_o,
    output logic              reg_we_o,
    output logic              reg_re_o,
    input  logic [7:0]        reg_rdata_i,
    output logic              frame_active_o,
    output logic [7:0]        byte_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_HOLD,
        S_RD_ISSUE,
        S_RD_CAPT,
        S_XFER,
        S_DATA_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        hold_q, hold_d;
    logic              is_read_q, is_read_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        txd_q, txd_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              rdy_ack_q, rdy_ack_d;
    logic              last_ack_q, last_ack_d;
    logic              we_q, we_d;
    logic              active_q, active_d;
    logic              rdy_ok;
    logic              last_ok;

    // Ready is still asserted by the slave for two edges after our ack; hold_q masks it.
    assign rdy_ok  = spi_rdy_i && (hold_q == 2'd0);
    assign last_ok = spi_last_byte_i && !last_ack_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
        is_read_d  = is_read_q;
        addr_d     = we_q ? addr_q + ADDR_W'(1) : addr_q;
        txd_d      = txd_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdy_ack_d  = 1'b0;
        last_ack_d = 1'b0;
        we_d       = 1'b0;
        active_d   = active_q;

        case (state_q)
            S_IDLE: begin
                txd_d = STATUS_BYTE;
                if (rdy_ok) begin
                    rdy_ack_d = 1'b1;
                    hold_d    = 2'd2;
                    if (spi_first_byte_i) begin
                        addr_d    = spi_data_i[ADDR_W-1:0];
                        is_read_d = spi_data_i[7];
                        cnt_d     = 8'd0;
                        active_d  = 1'b1;
                        state_d   = S_CMD_HOLD;
                    end
                end else if (last_ok) begin
                    last_ack_d = 1'b1;
                end
            end
            S_CMD_HOLD, S_DATA_HOLD: begin
                if (hold_q <= 2'd1) begin
                    state_d = is_read_q ? S_RD_ISSUE : S_XFER;
                end
            end
            S_RD_ISSUE: begin
                state_d = S_RD_CAPT;
            end
            S_RD_CAPT: begin
                txd_d   = reg_rdata_i;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_XFER;
            end
            S_XFER: begin
                // A pending word always wins over end-of-frame.
                if (rdy_ok) begin
                    rdy_ack_d = 1'b1;
                    hold_d    = 2'd2;
                    cnt_d     = (cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
                    if (!is_read_q) begin
                        we_d    = 1'b1;
                        wdata_d = spi_data_i;
                    end
                    state_d = S_DATA_HOLD;
                end else if (last_ok) begin
                    last_ack_d = 1'b1;
                    active_d   = 1'b0;
                    txd_d      = STATUS_BYTE;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!en_i) begin
            state_d    = S_IDLE;
            hold_d     = 2'd0;
            rdy_ack_d  = 1'b0;
            last_ack_d = 1'b0;
            we_d       = 1'b0;
            active_d   = 1'b0;
            txd_d      = STATUS_BYTE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            hold_q     <= 2'd0;
            is_read_q  <= 1'b0;
            addr_q     <= '0;
            txd_q      <= STATUS_BYTE;
            wdata_q    <= 8'd0;
            cnt_q      <= 8'd0;
            rdy_ack_q  <= 1'b0;
            last_ack_q <= 1'b0;
            we_q       <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            is_read_q  <= is_read_d;
            addr_q     <= addr_d;
            txd_q      <= txd_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdy_ack_q  <= rdy_ack_d;
            last_ack_q <= last_ack_d;
            we_q       <= we_d;
            active_q   <= active_d;
        end
    end

    assign spi_rdy_ack_o       = rdy_ack_q;
    assign spi_last_byte_ack_o = last_ack_q;
    assign spi_data_o          = txd_q;
    assign reg_addr_o          = addr_q;
    assign reg_wdata_o         = wdata_q;
    assign reg_we_o            = we_q;
    assign reg_re_o            = en_i && (state_q == S_RD_ISSUE);
    assign frame_active_o      = active_q;
    assign byte_cnt_o          = cnt_q;

endmodule

// File: doc/spi_slave_reg_ctrl.md
# spi_slave_reg_ctrl

Register-access controller that sequences the byte-level SPI slave datapath and turns each SPI frame into accesses on a simple 8-bit register bus.
- **Frame format:** the first byte of a frame is a command (R/W flag plus start address); the following bytes are write data or read dummies.
- **Address:** auto-increments after every data byte.
- **Handshakes:** the block acknowledges the slave's word-ready and end-of-frame flags and prefetches read data into the slave's TX word.
- **Placement:** sits between the SPI slave instance and a peripheral register file, entirely in the system clock domain.

## Interface
Parameters:
- `ADDR_W`, 7: register address width (1..7); addresses wrap modulo 2^ADDR_W.
- `STATUS_BYTE`, 8'hA5: byte presented on `spi_data_o` while idle / during the command byte.

Ports:
- `clk_i` in 1: system clock, single clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `en_i` in 1: block enable; low forces IDLE synchronously, with no register strobes.
- `spi_rdy_i` in 1: slave word-ready level; stays high until acknowledged.
- `spi_rdy_ack_o` out 1: one-cycle acknowledge of `spi_rdy_i`.
- `spi_data_i` in 8: received word from the slave.
- `spi_data_o` out 8: TX word to the slave.
- `spi_first_byte_i` in 1: slave flag, high while the first word of the frame is current.
- `spi_last_byte_i` in 1: slave end-of-frame flag (chip select released); stays high until acknowledged.
- `spi_last_byte_ack_o` out 1: one-cycle acknowledge of `spi_last_byte_i`.
- `reg_addr_o` out ADDR_W: register address.
- `reg_wdata_o` out 8: register write data.
- `reg_we_o` out 1: one-cycle write strobe.
- `reg_re_o` out 1: one-cycle read strobe.
- `reg_rdata_i` in 8: read data, valid the cycle after `reg_re_o`.
- `frame_active_o` out 1: high from command byte accepted to end-of-frame acknowledged.
- `byte_cnt_o` out 8: data bytes (excluding command) in the current/last frame; saturates at 255.

## Operation
- **Command byte format:** bit7 = 1 means read, 0 means write; bits[ADDR_W-1:0] = start address; unused bits are ignored.
- **FSM states:**
  - **IDLE:** `spi_data_o` = STATUS_BYTE. On `spi_rdy_i` with `spi_first_byte_i`: ack, latch address, clear `byte_cnt_o`, set `frame_active_o`, go to CMD_HOLD. If `spi_rdy_i` arrives with `spi_first_byte_i` low (stray word): ack and discard, stay IDLE.
  - **CMD_HOLD:** 2-edge holdoff, then go to RD_ISSUE if read, XFER if write.
  - **RD_ISSUE:** `reg_re_o` = 1 with the current address, go to RD_CAPT.
  - **RD_CAPT:** `spi_data_o` <= `reg_rdata_i`, address <= address+1, go to XFER.
  - **XFER:**
    - On `spi_rdy_i`: ack, `byte_cnt_o` +1 (saturating), then go to DATA_HOLD.
    - Write frame: `reg_we_o` = 1, `reg_wdata_o` = `spi_data_i`, address <= address+1 after the strobe.
    - Read frame: the received byte is discarded.
    - On `spi_last_byte_i` (and no `spi_rdy_i`): `spi_last_byte_ack_o` = 1, go to IDLE.
  - **DATA_HOLD:** 2-edge holdoff, then RD_ISSUE (read) or XFER (write).
- **Holdoff:** after any `spi_rdy_ack_o`, `spi_rdy_i` is ignored at the next two rising edges. The slave's ready output stays high for two edges after ack, and must not be double-counted.
- **Simultaneous events:** `spi_rdy_i` and `spi_last_byte_i` both high means the word is processed first (write strobe still issued). The last-byte ack follows after the holdoff. `spi_last_byte_i` is never acked while a word is pending.
- **Last-byte during holdoff or read fetch:** the sequence completes first, then the last-byte ack is issued.
- **End of frame:** `spi_last_byte_i` in IDLE (frame with no command) is acked and ignored. `frame_active_o` is cleared with the last-byte ack, and `spi_data_o` returns to STATUS_BYTE.
- **Read side effect:** a read frame always issues one prefetch `reg_re_o`, even with zero data bytes. N data bytes cause N+1 reads.
- **Address wrap:** address 2^ADDR_W-1 increments to 0.
- **Disable:** `en_i` low clears the FSM to IDLE next edge; all strobes and acks go to 0.

## Timing
- **Reset values (asynchronous):** all strobes/acks 0, `spi_data_o` = STATUS_BYTE, `reg_addr_o` = 0, `reg_wdata_o` = 0, `frame_active_o` = 0, `byte_cnt_o` = 0.
- **Write latency:** `spi_rdy_i` sampled high at edge E0 → `spi_rdy_ack_o` and `reg_we_o` high during E0–E1.
- **Read-ahead timing:** `reg_re_o` during E2–E3 (after holdoff, RD_ISSUE at E2), `spi_data_o` updated at E4.
- **Spacing constraint:** SPI byte period ≥ 6 `clk_i` cycles guarantees `spi_data_o` is stable before the slave loads the next TX word.
- **Strobe width:** every strobe/ack is exactly one cycle; `reg_we_o` and `reg_re_o` are never high together.

## Test plan
- **Write burst:** frame 0x12,0xAA,0xBB → `reg_we_o` twice: addr 0x12 data 0xAA, addr 0x13 data 0xBB. Then `byte_cnt_o` = 2, last-byte acked, `frame_active_o` = 0.
- **Read burst:** frame 0x85 + 2 dummies, reg file returns addr+0x40 → MISO bytes STATUS_BYTE, 0x45, 0x46. `reg_re_o` three times (0x05, 0x06, 0x07).
- **Wrap:** write frame at addr 0x7F with 2 data bytes → writes at 0x7F then 0x00.
- **Collision:** `spi_rdy_i` and `spi_last_byte_i` asserted same edge on a data byte → `reg_we_o` issued. Last-byte ack exactly 3 edges later. Exactly one `spi_rdy_ack_o`.
- **Holdoff:** slave ready held high 2 edges after ack → single `byte_cnt_o` increment, single write.
- **Reset/enable:** `rst_i` pulsed mid read burst → all outputs at reset values immediately. `en_i` low mid write → next edge IDLE, no further `reg_we_o`.
